// File: rtl/cmp_pkg.sv
// Shared constants for the frame peak tracker: data width, FSM state encoding
// and the values the result registers take out of reset.
package cmp_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MAX_RST = 8'h00;
  localparam logic [DATA_W-1:0] MIN_RST = 8'hFF;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned magnitude comparator; o_gt is high when i_a is strictly greater than i_b.
module eight_bit_comparator
  import cmp_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_gt
);

  assign o_gt = (i_a > i_b);

endmodule

// File: rtl/frame_peak_tracker.sv
// Per-frame max/min/count tracker with a valid/ready result handshake.
// Min tracking is built only when FRAME_MIN_TRACK_EN is defined; otherwise out_min reads 8'hFF.
module frame_peak_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_max;
  logic [CNT_W-1:0]   r_count;
  logic               r_sat;
  logic               w_accept;
  logic               w_max_gt;

  assign in_ready  = (r_state != ST_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_max   = r_max;
  assign out_count = r_count;
  assign out_sat   = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HOLD always passes through IDLE, so accept and release never share a cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (w_accept) begin
          w_state_next = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  eight_bit_comparator u_max_cmp (
    .i_a  (in_data),
    .i_b  (r_max),
    .o_gt (w_max_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max   <= MAX_RST;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_max   <= in_data;
        r_count <= CNT_W'(1);
        r_sat   <= 1'b0;
      end else begin
        if (w_max_gt) begin
          r_max <= in_data;
        end
        // Count pins at all-ones; the overflow is remembered in r_sat instead.
        if (&r_count) begin
          r_sat <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef FRAME_MIN_TRACK_EN
  logic [DATA_W-1:0] r_min;
  logic              w_min_gt;

  eight_bit_comparator u_min_cmp (
    .i_a  (r_min),
    .i_b  (in_data),
    .o_gt (w_min_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= MIN_RST;
    end else if (w_accept) begin
      if (r_state == ST_IDLE || w_min_gt) begin
        r_min <= in_data;
      end
    end
  end

  assign out_min = r_min;
`else
  assign out_min = MIN_RST;
`endif

endmodule

// File: tb/tb_frame_peak_tracker.sv
// Randomized bench for frame_peak_tracker: two instances (CNT_W=8 and CNT_W=2) share
// stimulus and are compared every cycle against a sample-queue reference model.
module tb_frame_peak_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_sat;
  logic [7:0] a_max, a_min, a_count;
  logic       b_in_ready, b_out_valid, b_sat;
  logic [7:0] b_max, b_min;
  logic [1:0] b_count;

  int total = 0;
  int bad   = 0;
  int ordy_mode = 2;  // 0 random, 1 forced low, 2 forced high
  int frames = 0;

  // reference model state
  bit         m_hold = 1'b0;
  logic [7:0] q[$];
  logic [7:0] frm[$];
  logic [7:0] e_max, e_min;
  int         e_n;

  always #5 clk = ~clk;

  frame_peak_tracker #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_max(a_max), .out_min(a_min), .out_count(a_count), .out_sat(a_sat)
  );

  frame_peak_tracker #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_max(b_max), .out_min(b_min), .out_count(b_count), .out_sat(b_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_cnt(input int n, input int w);
    int lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Frame results derived from the whole list of accepted samples.
  function automatic void close_frame();
    e_n   = q.size();
    e_max = 8'h00;
    e_min = 8'hFF;
    foreach (q[i]) begin
      if (q[i] > e_max) e_max = q[i];
      if (q[i] < e_min) e_min = q[i];
    end
`ifndef FRAME_MIN_TRACK_EN
    e_min = 8'hFF;
`endif
  endfunction

  always @(negedge rst_n) begin
    m_hold = 1'b0;
    q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (!m_hold) begin
        if (in_valid) begin
          q.push_back(in_data);
          if (in_last) begin
            close_frame();
            m_hold = 1'b1;
          end
        end
      end else if (out_ready) begin
        frames++;
        $display("frame %0d: n=%0d max=%02h min=%02h", frames, e_n, e_max, e_min);
        m_hold = 1'b0;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready_a", a_in_ready, !m_hold);
    check("out_valid_a", a_out_valid, m_hold);
    check("in_ready_b", b_in_ready, !m_hold);
    check("out_valid_b", b_out_valid, m_hold);
    if (!rst_n) begin
      check("rst_max", a_max, 8'h00);
      check("rst_min", a_min, 8'hFF);
      check("rst_count", a_count, 0);
      check("rst_sat", a_sat, 0);
      check("rst_count_b", b_count, 0);
    end else if (m_hold) begin
      check("max_a", a_max, e_max);
      check("min_a", a_min, e_min);
      check("count_a", a_count, sat_cnt(e_n, 8));
      check("sat_a", a_sat, e_n > 255);
      check("max_b", b_max, e_max);
      check("min_b", b_min, e_min);
      check("count_b", b_count, sat_cnt(e_n, 2));
      check("sat_b", b_sat, e_n > 3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ordy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic send_sample(input logic [7:0] d, input logic last);
    bit acc = 1'b0;
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      k++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frm[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end
      send_sample(frm[i], i == frm.size() - 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // mixed frame with a repeated maximum
    ordy_mode = 2;
    frm = '{8'd10, 8'd50, 8'd50, 8'd7};
    send_frame(0);
    tick();

    // single-sample frame
    frm = '{8'hA5};
    send_frame(0);
    tick();

    // saturation of the narrow counter
    frm = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_frame(0);
    tick();

    // back-pressure in HOLD with the next sample already waiting
    ordy_mode = 1;
    frm = '{8'd20, 8'd30};
    send_frame(0);
    in_valid = 1'b1;
    in_data  = 8'd77;
    in_last  = 1'b0;
    repeat (4) tick();
    ordy_mode = 2;
    send_sample(8'd77, 1'b0);
    send_sample(8'd80, 1'b1);
    tick();

    // reset in mid-frame, then a fresh frame right after release
    send_sample(8'd11, 1'b0);
    send_sample(8'd200, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    frm = '{8'd3, 8'd9};
    send_frame(0);
    tick();

    // reset while a result is held
    ordy_mode = 1;
    frm = '{8'd40};
    send_frame(0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ordy_mode = 2;
    repeat (2) tick();

    // long frame saturating the wide counter
    frm.delete();
    for (int i = 0; i < 300; i++) frm.push_back(8'($urandom));
    send_frame(0);
    tick();

    // random frames, random gaps and random consumer stalls
    ordy_mode = 0;
    for (int f = 0; f < 40; f++) begin
      frm.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        frm.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
      end
      send_frame(1);
    end

    ordy_mode = 2;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_peak_tracker.md
FRAME_PEAK_TRACKER -- requirements
Module: frame_peak_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the per-frame sample counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: sample present on in_data.
REQ-005 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-006 SHALL have port in_data, input, 8: unsigned sample.
REQ-007 SHALL have port in_last, input, 1: the accepted sample closes the frame.
REQ-008 SHALL have port out_valid, output, 1: frame result held on the out_* ports.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port out_max, output, 8: largest sample in the frame.
REQ-011 SHALL have port out_min, output, 8: smallest sample in the frame.
REQ-012 SHALL have port out_count, output, CNT_W: number of samples in the frame.
REQ-013 SHALL have port out_sat, output, 1: the frame length exceeded 2^CNT_W-1.

Function
REQ-014 SHALL be a three-state FSM: IDLE (no sample yet in frame), ACC (frame open), HOLD (result presented).
REQ-015 A sample SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-016 SHALL load max=min=in_data and count=1 on acceptance in IDLE, going to ACC, or to HOLD if in_last is high.
REQ-017 In ACC, max SHALL update only when in_data is strictly greater than max (comparator greater output); an equal sample SHALL leave max unchanged.
REQ-018 In ACC, min SHALL update only when min is strictly greater than in_data.
REQ-019 Count SHALL increment per accepted sample and saturate at all-ones; out_sat SHALL set on an attempted increment past all-ones and stay set until the frame is consumed.
REQ-020 Acceptance with in_last SHALL move to HOLD; out_valid SHALL assert the next cycle, with the results including that last sample (latency 1).
REQ-021 In HOLD, out_* SHALL stay stable while out_ready is 0; on out_ready=1 the FSM SHALL return to IDLE and out_valid SHALL drop the next cycle.
REQ-022 A frame with one sample (in_last on the first sample) SHALL give out_max=out_min=sample and out_count=1.
REQ-023 The cycle after HOLD exits SHALL be a one-cycle bubble (IDLE, in_ready=1); there SHALL be no same-cycle accept-and-release.
REQ-024 in_valid=0 SHALL never change state; gaps inside a frame SHALL be allowed.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, out_valid=0, out_max=8'h00, out_min=8'hFF, out_count=0, out_sat=0.
REQ-026 A reset in mid-frame or in HOLD SHALL discard the partial result; no out_valid SHALL follow.
REQ-027 in_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-028 Macro FRAME_MIN_TRACK_EN SHALL enable min tracking as in REQ-016/018.
REQ-029 Without FRAME_MIN_TRACK_EN, the min register and its comparator SHALL be absent, out_min SHALL be tied to 8'hFF, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package cmp_pkg SHALL hold DATA_W=8, the FSM state encoding (IDLE/ACC/HOLD) and the reset constants 8'h00/8'hFF.
REQ-031 Magnitude comparisons SHALL use eight_bit_comparator as the sub-module: one instance for max and a second instance only under FRAME_MIN_TRACK_EN.

Verification
REQ-032 Frame 10,50,50,7(last), out_ready=1 -> out_max=50, out_min=7, out_count=4, out_valid one cycle after the last accept.
REQ-033 Single sample 8'hA5 with in_last -> out_max=out_min=8'hA5, out_count=1.
REQ-034 CNT_W=2, frame of 5 samples of 8'h01 -> out_count=3, out_sat=1.
REQ-035 out_ready held 0 for 4 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no sample lost; the next frame is accepted after release.
REQ-036 rst_n low after 2 samples of a frame, then a new frame 3,9(last) -> out_max=9, out_min=3, out_count=2.
REQ-037 Build without FRAME_MIN_TRACK_EN, frame 4,2(last) -> out_max=4, out_min=8'hFF.
